// File: rtl/instr_fetch_mem.sv
// Instruction memory for the datapath fetch port.
// A ready/valid byte stream loads a program. While a load is in progress the
// datapath is held. In RUN, the word at PC is returned one clock after PC is
// presented. Words at or beyond the loaded length read back as FILL.
module instr_fetch_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  FILL   = 8'h00
) (
  input  logic              _CLK,
  input  logic              RESET_N,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   prog_len,
  input  logic [ADDR_W-1:0] PC,
  output logic [7:0]        instruction,
  output logic              cpu_hold
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Index of the last storage word; accepting it ends the load without load_last.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              load_ready_q, load_ready_d;
  logic              load_done_q, load_done_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic [7:0]        instruction_q, instruction_d;
  logic [7:0]        mem_q [DEPTH];

  logic              accept_s;
  logic              write_s;
  logic              end_of_load_s;

  // load_ready_q is only ever set in LOAD, so it also qualifies the state.
  // A restart in the same cycle drops the beat.
  assign accept_s      = load_valid & load_ready_q;
  assign write_s       = accept_s & ~load_start;
  assign end_of_load_s = write_s & (load_last | (wptr_q == LAST_IDX));

  // Next-state logic for the IDLE/LOAD/RUN controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          state_d = ST_LOAD;
        end else if (end_of_load_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write pointer and program length. A restart clears both; each written word advances both.
  always_comb begin
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    if (load_start) begin
      wptr_d     = '0;
      prog_len_d = '0;
    end else if (write_s) begin
      wptr_d     = wptr_q + (ADDR_W+1)'(1);
      prog_len_d = wptr_q + (ADDR_W+1)'(1);
    end else begin
      wptr_d     = wptr_q;
      prog_len_d = prog_len_q;
    end
  end

  // Output next-values. The fetch in RUN still completes on the edge that sees a restart.
  always_comb begin
    load_ready_d  = (state_d == ST_LOAD);
    load_done_d   = (state_q == ST_LOAD) && (state_d == ST_RUN);
    cpu_hold_d    = (state_d != ST_RUN);
    instruction_d = FILL;
    if (state_q == ST_RUN) begin
      if ({1'b0, PC} < prog_len_q) begin
        instruction_d = mem_q[PC];
      end else begin
        instruction_d = FILL;
      end
    end else begin
      instruction_d = FILL;
    end
  end

  // Registered state, pointers and outputs with asynchronous reset.
  always_ff @(posedge _CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      wptr_q        <= '0;
      prog_len_q    <= '0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      cpu_hold_q    <= 1'b1;
      instruction_q <= FILL;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      prog_len_q    <= prog_len_d;
      load_ready_q  <= load_ready_d;
      load_done_q   <= load_done_d;
      cpu_hold_q    <= cpu_hold_d;
      instruction_q <= instruction_d;
    end
  end

  // Storage array. It is never cleared, because prog_len masks any stale words.
  always_ff @(posedge _CLK) begin
    if (write_s) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= load_data;
    end
  end

  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign prog_len    = prog_len_q;
  assign cpu_hold    = cpu_hold_q;
  assign instruction = instruction_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem.
// A reference array is built from the words driven on the load stream.
// Each fetch pushes its expected word into a scoreboard queue.
// The queue is popped and compared one edge later.
module tb_instr_fetch_mem;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   prog_len;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        instruction;
  logic              cpu_hold;

  int          tests_run;
  int          tests_failed;
  logic [7:0]  exp_mem [DEPTH];
  int          exp_len;
  logic [7:0]  sb_q [$];

  instr_fetch_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL(8'h00)) dut (
    ._CLK        (clk),
    .RESET_N     (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .prog_len    (prog_len),
    .PC          (pc),
    .instruction (instruction),
    .cpu_hold    (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present PC, queue the word the reference model expects, and advance one edge.
  task automatic drive_fetch(input int addr);
    pc = addr[ADDR_W-1:0];
    if (addr < exp_len) sb_q.push_back(exp_mem[addr]);
    else                sb_q.push_back(8'h00);
    tick();
  endtask

  // Restart a load and stream the words, optionally with two idle cycles before each later word.
  // Counts load_done pulses and words presented while load_ready was high.
  task automatic do_load(input logic [7:0] data[$], input bit gaps, input bit use_last,
                         output int done_cnt, output int acc_cnt);
    int n;
    done_cnt = 0;
    acc_cnt  = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < data.size(); i++) begin
      if (gaps && i > 0) begin
        load_valid = 1'b0;
        repeat (2) begin
          tick();
          if (load_done === 1'b1) done_cnt++;
        end
      end
      load_valid = 1'b1;
      load_data  = data[i];
      load_last  = use_last && (i == data.size() - 1);
      if (load_ready === 1'b1) acc_cnt++;
      tick();
      if (load_done === 1'b1) done_cnt++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (3) begin
      tick();
      if (load_done === 1'b1) done_cnt++;
    end
    n = (data.size() < DEPTH) ? data.size() : DEPTH;
    exp_len = n;
    for (int i = 0; i < n; i++) exp_mem[i] = data[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (instruction !== 8'h00) begin
      $display("FAIL reset_instr got=%h exp=00", instruction); tests_failed++;
    end
    tests_run++;
    if (cpu_hold !== 1'b1 || load_ready !== 1'b0 || load_done !== 1'b0) begin
      $display("FAIL reset_ctrl got hold=%b ready=%b done=%b exp 1/0/0", cpu_hold, load_ready, load_done);
      tests_failed++;
    end
    tests_run++;
    if (prog_len !== 5'd0) begin
      $display("FAIL reset_len got=%0d exp=0", prog_len); tests_failed++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load();
    logic [7:0] q [$];
    int done_cnt, acc_cnt;
    logic [7:0] got, exp;
    q = '{8'h71, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hC2};
    do_load(q, 1'b0, 1'b1, done_cnt, acc_cnt);
    tests_run++;
    if (prog_len !== 5'd6 || done_cnt != 1 || cpu_hold !== 1'b0) begin
      $display("FAIL basic_load got len=%0d done=%0d hold=%b exp 6/1/0", prog_len, done_cnt, cpu_hold);
      tests_failed++;
    end
    foreach (q[i]) begin
      if (i == 3 || i == 5 || i == 0) begin
        drive_fetch(i);
        got = instruction; exp = sb_q.pop_front();
        tests_run++;
        if (got !== exp) begin
          $display("FAIL basic_fetch pc=%0d got=%h exp=%h", i, got, exp); tests_failed++;
        end
      end
    end
    drive_fetch(6);
    got = instruction; exp = sb_q.pop_front();
    tests_run++;
    if (got !== exp || got !== 8'h00) begin
      $display("FAIL basic_fill pc=6 got=%h exp=00", got); tests_failed++;
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] q [$];
    int done_cnt, acc_cnt;
    logic [7:0] got, exp;
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'h10 + 8'(i));
    do_load(q, 1'b0, 1'b0, done_cnt, acc_cnt);
    tests_run++;
    if (acc_cnt != 16 || prog_len !== 5'd16 || done_cnt != 1 || load_ready !== 1'b0) begin
      $display("FAIL full_depth got acc=%0d len=%0d done=%0d ready=%b exp 16/16/1/0",
               acc_cnt, prog_len, done_cnt, load_ready);
      tests_failed++;
    end
    drive_fetch(15);
    got = instruction; exp = sb_q.pop_front();
    tests_run++;
    if (got !== exp || got !== 8'h1F) begin
      $display("FAIL full_fetch15 got=%h exp=1f", got); tests_failed++;
    end
  endtask

  task automatic test_gapped_load();
    logic [7:0] q [$];
    int done_cnt, acc_cnt;
    logic [7:0] got, exp;
    q = '{8'h71, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hC2};
    do_load(q, 1'b1, 1'b1, done_cnt, acc_cnt);
    tests_run++;
    if (prog_len !== 5'd6 || done_cnt != 1) begin
      $display("FAIL gap_load got len=%0d done=%0d exp 6/1", prog_len, done_cnt); tests_failed++;
    end
    for (int a = 0; a < 8; a++) begin
      drive_fetch(a);
      got = instruction; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        $display("FAIL gap_fetch pc=%0d got=%h exp=%h", a, got, exp); tests_failed++;
      end
    end
  endtask

  task automatic test_reload_in_run();
    logic [7:0] q [$];
    int done_cnt, acc_cnt;
    logic [7:0] got, exp;
    pc = 4'd2;
    load_start = 1'b1;
    sb_q.push_back(8'h74);
    tick();
    load_start = 1'b0;
    got = instruction; exp = sb_q.pop_front();
    tests_run++;
    if (got !== exp || cpu_hold !== 1'b1 || prog_len !== 5'd0) begin
      $display("FAIL reload_edge got ins=%h hold=%b len=%0d exp %h/1/0", got, cpu_hold, prog_len, exp);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (instruction !== 8'h00 || cpu_hold !== 1'b1) begin
      $display("FAIL reload_hold got ins=%h hold=%b exp 00/1", instruction, cpu_hold); tests_failed++;
    end
    q = '{8'hAA};
    do_load(q, 1'b0, 1'b1, done_cnt, acc_cnt);
    for (int a = 0; a < 2; a++) begin
      drive_fetch(a);
      got = instruction; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        $display("FAIL reload_fetch pc=%0d got=%h exp=%h", a, got, exp); tests_failed++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] q [$];
    int done_cnt, acc_cnt;
    logic [7:0] got, exp;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h11; tick();
    load_data = 8'h22; tick();
    // A restart collides with a valid beat; the beat must be dropped.
    load_start = 1'b1; load_data = 8'hEE; tick();
    load_start = 1'b0;
    tests_run++;
    if (prog_len !== 5'd0 || load_ready !== 1'b1) begin
      $display("FAIL collide got len=%0d ready=%b exp 0/1", prog_len, load_ready); tests_failed++;
    end
    load_data = 8'h11; tick();
    load_data = 8'h22; tick();
    load_data = 8'h33; tick();
    load_valid = 1'b0;
    tests_run++;
    if (prog_len !== 5'd3) begin
      $display("FAIL partial_len got=%0d exp=3", prog_len); tests_failed++;
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (prog_len !== 5'd0 || cpu_hold !== 1'b1 || load_ready !== 1'b0 || instruction !== 8'h00) begin
      $display("FAIL async_reset got len=%0d hold=%b ready=%b ins=%h exp 0/1/0/00",
               prog_len, cpu_hold, load_ready, instruction);
      tests_failed++;
    end
    tick();
    rst_n = 1'b1;
    exp_len = 0;
    load_valid = 1'b1; load_data = 8'h99; tick();
    load_valid = 1'b0;
    tests_run++;
    if (load_ready !== 1'b0 || prog_len !== 5'd0 || cpu_hold !== 1'b1) begin
      $display("FAIL idle_ignore got ready=%b len=%0d hold=%b exp 0/0/1", load_ready, prog_len, cpu_hold);
      tests_failed++;
    end
    q = '{8'h5A};
    do_load(q, 1'b0, 1'b1, done_cnt, acc_cnt);
    tests_run++;
    if (prog_len !== 5'd1 || done_cnt != 1 || cpu_hold !== 1'b0) begin
      $display("FAIL post_reset_load got len=%0d done=%0d hold=%b exp 1/1/0", prog_len, done_cnt, cpu_hold);
      tests_failed++;
    end
    for (int a = 0; a < 2; a++) begin
      drive_fetch(a);
      got = instruction; exp = sb_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        $display("FAIL post_reset_fetch pc=%0d got=%h exp=%h", a, got, exp); tests_failed++;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_len      = 0;
    rst_n        = 1'b0;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_data    = 8'h00;
    load_last    = 1'b0;
    pc           = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
    test_reset();
    test_basic_load();
    test_full_depth();
    test_gapped_load();
    test_reload_in_run();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
